// File: rtl/if_prefetch.sv
// if_prefetch: MIPS instruction-fetch front end with prefetch FIFO.
// Drives the IF/ID register (inst_s2, pc4_s2, inst_valid) from a small queue
// filled over a req/ack instruction-memory handshake. One request is
// outstanding at most; redirects flush the queue and discard in-flight data.
// Optional build macro: IF_PREFETCH_STATS_EN adds bubble_cnt / drop_cnt.
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic [31:0] inst_s2,
    output logic [31:0] pc4_s2,
    output logic        inst_valid
`ifdef IF_PREFETCH_STATS_EN
    ,
    output logic [15:0] bubble_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = 64;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   addr_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [EW-1:0] fifo_q [DEPTH];
    logic [31:0]   inst_q, pc4_q;
    logic          valid_q;

    logic req_c, issue_c, push_c, pop_c, drop_c, full_c, empty_c;
    logic unused_pc_bits;

    // Low address bits of the redirect target are ignored by design.
    assign unused_pc_bits = ^redirect_pc[1:0];

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

    // Fetch FSM next state and request generation.
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        issue_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!redirect && !full_c) begin
                    req_c   = 1'b1;
                    issue_c = 1'b1;
                    state_d = imem_ack ? S_IDLE : S_BUSY;
                end
            end
            S_BUSY: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            req_c   = 1'b0;
            issue_c = 1'b0;
        end
    end

    // A response is kept only if it belongs to a live request and no redirect hits it.
    assign push_c = req_c && imem_ack && (state_q != S_DROP) && !redirect;
    assign drop_c = req_c && imem_ack && ((state_q == S_DROP) || redirect);
    assign pop_c  = !redirect && !hold && !empty_c;

    assign imem_req  = req_c;
    assign imem_addr = (state_q == S_IDLE) ? fpc_q : addr_q;

    // Fetch PC: redirect wins, otherwise advance on each accepted word.
    always_comb begin
        fpc_d = fpc_q;
        if (redirect) begin
            fpc_d = {redirect_pc[31:2], 2'b00};
        end else if (push_c) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC, latched request address, and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q    <= RESET_PC;
            addr_q   <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q <= fpc_d;
            if (issue_c) begin
                addr_q <= fpc_q;
            end
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_c) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop_c) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_q + CW'(push_c) - CW'(pop_c);
            end
        end
    end

    // FIFO storage; entry is {pc+4, instruction}.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= {fpc_q + 32'd4, imem_rdata};
        end
    end

    // IF/ID register: redirect > hold > pop/bubble.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            inst_q  <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (!hold) begin
            if (pop_c) begin
                pc4_q   <= fifo_q[rd_ptr_q][63:32];
                inst_q  <= fifo_q[rd_ptr_q][31:0];
                valid_q <= 1'b1;
            end else begin
                inst_q  <= '0;
                pc4_q   <= '0;
                valid_q <= 1'b0;
            end
        end
    end

    assign inst_s2    = inst_q;
    assign pc4_s2     = pc4_q;
    assign inst_valid = valid_q;

`ifdef IF_PREFETCH_STATS_EN
    logic [15:0] bubble_q, drop_q;

    // Saturating counters for empty-FIFO bubbles and discarded responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_q <= '0;
            drop_q   <= '0;
        end else begin
            if (!redirect && !hold && empty_c && (bubble_q != 16'hFFFF)) begin
                bubble_q <= bubble_q + 16'd1;
            end
            if (drop_c && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign bubble_cnt = bubble_q;
    assign drop_cnt   = drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop_c;
`endif

endmodule
